// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite read channel among NUM_REQ requesters,
// one single-beat read in flight. Define ARB_TIMEOUT_EN to add the R-phase watchdog and FLUSH state.
module axi_read_arbiter #(
    parameter int NUM_REQ            = 4,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES     = 256
) (
    input  logic                                  M_AXI_ACLK,
    input  logic                                  M_AXI_ARESET,
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  logic [NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]                    req_ready,
    output logic [NUM_REQ-1:0]                    rsp_valid,
    input  logic [NUM_REQ-1:0]                    rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]         rsp_data,
    output logic [1:0]                            rsp_resp,
    output logic                                  M_AXI_ARVALID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]         M_AXI_ARADDR,
    input  logic                                  M_AXI_ARREADY,
    input  logic                                  M_AXI_RVALID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]         M_AXI_RDATA,
    input  logic [1:0]                            M_AXI_RRESP,
    output logic                                  M_AXI_RREADY,
    output logic                                  timeout_err
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int IW = $clog2(NUM_REQ);

`ifdef ARB_TIMEOUT_EN
    typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, FLUSH} state_t;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
`else
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
`endif

    state_t             state_reg, state_next;
    // The latched winner doubles as last_grant for the next rotation.
    logic [IW-1:0]      grant_reg, grant_next;
    logic [NUM_REQ-1:0] req_ready_reg, req_ready_next;
    logic [NUM_REQ-1:0] rsp_valid_reg, rsp_valid_next;
    logic [DW-1:0]      rsp_data_reg, rsp_data_next;
    logic [1:0]         rsp_resp_reg, rsp_resp_next;
    logic               arvalid_reg, arvalid_next;
    logic [AW-1:0]      araddr_reg, araddr_next;
    logic               rready_reg, rready_next;
`ifdef ARB_TIMEOUT_EN
    logic [CW-1:0]      cnt_reg, cnt_next;
    logic               timed_out_reg, timed_out_next;
    logic               timeout_err_reg, timeout_err_next;
`endif

    logic [AW-1:0]      req_addr_arr [NUM_REQ];
    logic               rr_found;
    logic [IW-1:0]      rr_winner;
    logic [IW-1:0]      rr_cand;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_addr
            assign req_addr_arr[gi] = req_addr[gi*AW +: AW];
        end
    endgenerate

    // First requesting index after the previous winner, wrapping around.
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = grant_reg;
        rr_cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_cand = IW'((int'(grant_reg) + k) % NUM_REQ);
            if (!rr_found && req_valid[rr_cand]) begin
                rr_found  = 1'b1;
                rr_winner = rr_cand;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        req_ready_next = '0;
        rsp_valid_next = rsp_valid_reg;
        rsp_data_next  = rsp_data_reg;
        rsp_resp_next  = rsp_resp_reg;
        arvalid_next   = arvalid_reg;
        araddr_next    = araddr_reg;
        rready_next    = rready_reg;
`ifdef ARB_TIMEOUT_EN
        cnt_next         = cnt_reg;
        timed_out_next   = timed_out_reg;
        timeout_err_next = timeout_err_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (rr_found) begin
                    grant_next                = rr_winner;
                    araddr_next               = req_addr_arr[rr_winner];
                    arvalid_next              = 1'b1;
                    req_ready_next[rr_winner] = 1'b1;
                    state_next                = ADDR;
                end
            end
            ADDR: begin
                if (M_AXI_ARREADY) begin
                    arvalid_next = 1'b0;
                    rready_next  = 1'b1;
                    state_next   = DATA;
`ifdef ARB_TIMEOUT_EN
                    cnt_next     = '0;
`endif
                end
            end
            DATA: begin
                if (M_AXI_RVALID && rready_reg) begin
                    rsp_data_next             = M_AXI_RDATA;
                    rsp_resp_next             = M_AXI_RRESP;
                    rready_next               = 1'b0;
                    rsp_valid_next[grant_reg] = 1'b1;
                    state_next                = RESP;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_reg == CW'(TIMEOUT_CYCLES - 1)) begin
                    // Abandon the beat with a synthesized SLVERR; FLUSH absorbs it later.
                    rsp_data_next             = '0;
                    rsp_resp_next             = 2'b10;
                    rready_next               = 1'b0;
                    rsp_valid_next[grant_reg] = 1'b1;
                    timed_out_next            = 1'b1;
                    timeout_err_next          = 1'b1;
                    state_next                = RESP;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
`endif
            end
            RESP: begin
                if (rsp_ready[grant_reg]) begin
                    rsp_valid_next = '0;
`ifdef ARB_TIMEOUT_EN
                    if (timed_out_reg) begin
                        timed_out_next = 1'b0;
                        rready_next    = 1'b1;
                        state_next     = FLUSH;
                    end else begin
                        state_next = IDLE;
                    end
`else
                    state_next = IDLE;
`endif
                end
            end
`ifdef ARB_TIMEOUT_EN
            FLUSH: begin
                if (M_AXI_RVALID && rready_reg) begin
                    rready_next = 1'b0;
                    state_next  = IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state_reg     <= IDLE;
            grant_reg     <= IW'(NUM_REQ - 1);
            req_ready_reg <= '0;
            rsp_valid_reg <= '0;
            rsp_data_reg  <= '0;
            rsp_resp_reg  <= '0;
            arvalid_reg   <= 1'b0;
            araddr_reg    <= '0;
            rready_reg    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_reg         <= '0;
            timed_out_reg   <= 1'b0;
            timeout_err_reg <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            req_ready_reg <= req_ready_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_data_reg  <= rsp_data_next;
            rsp_resp_reg  <= rsp_resp_next;
            arvalid_reg   <= arvalid_next;
            araddr_reg    <= araddr_next;
            rready_reg    <= rready_next;
`ifdef ARB_TIMEOUT_EN
            cnt_reg         <= cnt_next;
            timed_out_reg   <= timed_out_next;
            timeout_err_reg <= timeout_err_next;
`endif
        end
    end

    assign req_ready     = req_ready_reg;
    assign rsp_valid     = rsp_valid_reg;
    assign rsp_data      = rsp_data_reg;
    assign rsp_resp      = rsp_resp_reg;
    assign M_AXI_ARVALID = arvalid_reg;
    assign M_AXI_ARADDR  = araddr_reg;
    assign M_AXI_RREADY  = rready_reg;
`ifdef ARB_TIMEOUT_EN
    assign timeout_err   = timeout_err_reg;
`else
    assign timeout_err   = 1'b0;
`endif

endmodule
